// File: rtl/slurm_cpu_execute_hs.sv
// SLURM CPU execute stage with valid/ready memory and port handshakes and upstream stall.
// Optional bus timeout is enabled by defining SLURM_EXEC_TIMEOUT_EN.
module slurm_cpu_execute_hs #(
   parameter int unsigned BITS           = 16,
   parameter int unsigned ADDRESS_BITS   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    CLK,
   input  logic                    RSTb,
   input  logic                    ins_valid,
   input  logic [2:0]              op_class,
   input  logic [4:0]              op_alu,
   input  logic                    op_imm_b,
   input  logic                    op_write,
   input  logic [2:0]              op_cond,
   input  logic                    op_iret,
   input  logic                    op_ien,
   input  logic [3:0]              op_vector,
   input  logic                    Z,
   input  logic                    C,
   input  logic                    S,
   input  logic [BITS-1:0]         regA,
   input  logic [BITS-1:0]         regB,
   input  logic [BITS-1:0]         imm_reg,
   output logic [4:0]              aluOp,
   output logic [BITS-1:0]         aluA,
   output logic [BITS-1:0]         aluB,
   output logic                    load_pc,
   output logic [ADDRESS_BITS-1:0] new_pc,
   output logic                    int_set,
   output logic                    int_clear,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic [BITS-1:0]         mem_wdata,
   input  logic [BITS-1:0]         mem_rdata,
   output logic                    io_valid,
   input  logic                    io_ready,
   output logic                    io_write,
   output logic [ADDRESS_BITS-1:0] io_addr,
   output logic [BITS-1:0]         io_wdata,
   input  logic [BITS-1:0]         io_rdata,
   output logic [BITS-1:0]         rdata,
   output logic                    rdata_valid,
   output logic                    stall,
   output logic                    bus_error
);

   localparam logic [2:0] OpNop    = 3'd0;
   localparam logic [2:0] OpAlu    = 3'd1;
   localparam logic [2:0] OpBranch = 3'd2;
   localparam logic [2:0] OpRet    = 3'd3;
   localparam logic [2:0] OpInt    = 3'd4;
   localparam logic [2:0] OpLdst   = 3'd5;
   localparam logic [2:0] OpIo     = 3'd6;
   localparam logic [2:0] OpIflag  = 3'd7;

   typedef enum logic [1:0] {StIdle, StMemWait, StIoWait} state_e;

   state_e                  state_q, state_d;
   logic [4:0]              alu_op_q, alu_op_d;
   logic [BITS-1:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic                    load_pc_q, load_pc_d;
   logic [ADDRESS_BITS-1:0] new_pc_q, new_pc_d;
   logic                    int_set_q, int_set_d, int_clear_q, int_clear_d;
   logic                    mem_valid_q, mem_valid_d, mem_write_q, mem_write_d;
   logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
   logic [BITS-1:0]         mem_wdata_q, mem_wdata_d;
   logic                    io_valid_q, io_valid_d, io_write_q, io_write_d;
   logic [ADDRESS_BITS-1:0] io_addr_q, io_addr_d;
   logic [BITS-1:0]         io_wdata_q, io_wdata_d;
   logic [BITS-1:0]         rdata_q, rdata_d;
   logic                    rdata_valid_q, rdata_valid_d;

   logic [ADDRESS_BITS-1:0] bus_addr, branch_target;
   logic [BITS-1:0]         bus_wdata;
   logic                    cond_true;

`ifdef SLURM_EXEC_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout;
   logic            bus_error_q, bus_error_d;

   assign timeout = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Both address adders wrap modulo 2^ADDRESS_BITS.
   assign bus_addr      = ADDRESS_BITS'(regB) + ADDRESS_BITS'(imm_reg);
   assign branch_target = ADDRESS_BITS'(regA) + ADDRESS_BITS'(imm_reg);
   assign bus_wdata     = op_write ? regA : '0;

   always_comb begin
      cond_true = 1'b0;
      case (op_cond)
         3'd0: cond_true = 1'b1;
         3'd1: cond_true = Z;
         3'd2: cond_true = !Z;
         3'd3: cond_true = C;
         3'd4: cond_true = !C;
         3'd5: cond_true = S;
         3'd6: cond_true = !S;
         3'd7: cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      alu_op_d      = '0;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      load_pc_d     = 1'b0;
      new_pc_d      = new_pc_q;
      int_set_d     = 1'b0;
      int_clear_d   = 1'b0;
      mem_valid_d   = mem_valid_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      io_valid_d    = io_valid_q;
      io_write_d    = io_write_q;
      io_addr_d     = io_addr_q;
      io_wdata_d    = io_wdata_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
`ifdef SLURM_EXEC_TIMEOUT_EN
      wait_cnt_d    = '0;
      bus_error_d   = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            if (ins_valid) begin
               case (op_class)
                  OpAlu: begin
                     alu_op_d = op_alu;
                     alu_a_d  = regA;
                     alu_b_d  = op_imm_b ? imm_reg : regB;
                  end
                  OpBranch: begin
                     if (cond_true) begin
                        load_pc_d = 1'b1;
                        new_pc_d  = branch_target;
                     end
                  end
                  OpRet: begin
                     load_pc_d = 1'b1;
                     new_pc_d  = ADDRESS_BITS'(regA);
                     int_set_d = op_iret;
                  end
                  OpInt: begin
                     load_pc_d = 1'b1;
                     new_pc_d  = ADDRESS_BITS'({op_vector, 1'b0});
                  end
                  OpLdst: begin
                     mem_valid_d = 1'b1;
                     mem_write_d = op_write;
                     mem_addr_d  = bus_addr;
                     mem_wdata_d = bus_wdata;
                     state_d     = StMemWait;
                  end
                  OpIo: begin
                     io_valid_d = 1'b1;
                     io_write_d = op_write;
                     io_addr_d  = bus_addr;
                     io_wdata_d = bus_wdata;
                     state_d    = StIoWait;
                  end
                  OpIflag: begin
                     int_set_d   = op_ien;
                     int_clear_d = !op_ien;
                  end
                  OpNop:   ;
                  default: ;
               endcase
            end
         end
         StMemWait: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               state_d     = StIdle;
               if (!mem_write_q) begin
                  rdata_d       = mem_rdata;
                  rdata_valid_d = 1'b1;
               end
`ifdef SLURM_EXEC_TIMEOUT_EN
            end else if (timeout) begin
               mem_valid_d = 1'b0;
               bus_error_d = 1'b1;
               state_d     = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
         end
         StIoWait: begin
            if (io_ready) begin
               io_valid_d = 1'b0;
               state_d    = StIdle;
               if (!io_write_q) begin
                  rdata_d       = io_rdata;
                  rdata_valid_d = 1'b1;
               end
`ifdef SLURM_EXEC_TIMEOUT_EN
            end else if (timeout) begin
               io_valid_d  = 1'b0;
               bus_error_d = 1'b1;
               state_d     = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         state_q       <= StIdle;
         alu_op_q      <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         load_pc_q     <= 1'b0;
         new_pc_q      <= '0;
         int_set_q     <= 1'b0;
         int_clear_q   <= 1'b0;
         mem_valid_q   <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         io_valid_q    <= 1'b0;
         io_write_q    <= 1'b0;
         io_addr_q     <= '0;
         io_wdata_q    <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         alu_op_q      <= alu_op_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         load_pc_q     <= load_pc_d;
         new_pc_q      <= new_pc_d;
         int_set_q     <= int_set_d;
         int_clear_q   <= int_clear_d;
         mem_valid_q   <= mem_valid_d;
         mem_write_q   <= mem_write_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         io_valid_q    <= io_valid_d;
         io_write_q    <= io_write_d;
         io_addr_q     <= io_addr_d;
         io_wdata_q    <= io_wdata_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
      end
   end

`ifdef SLURM_EXEC_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         wait_cnt_q  <= '0;
         bus_error_q <= 1'b0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         bus_error_q <= bus_error_d;
      end
   end
   assign bus_error = bus_error_q;
`else
   assign bus_error = 1'b0;
`endif

   assign aluOp       = alu_op_q;
   assign aluA        = alu_a_q;
   assign aluB        = alu_b_q;
   assign load_pc     = load_pc_q;
   assign new_pc      = new_pc_q;
   assign int_set     = int_set_q;
   assign int_clear   = int_clear_q;
   assign mem_valid   = mem_valid_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign io_valid    = io_valid_q;
   assign io_write    = io_write_q;
   assign io_addr     = io_addr_q;
   assign io_wdata    = io_wdata_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign stall       = (state_q != StIdle);

endmodule

// File: tb/tb_slurm_cpu_execute_hs.sv
// Directed self-checking bench for slurm_cpu_execute_hs; inputs driven and outputs sampled
// on the falling edge.
module tb_slurm_cpu_execute_hs;

   localparam int unsigned BITS = 16;
   localparam int unsigned AB   = 16;

   logic            CLK = 1'b0;
   logic            RSTb;
   logic            ins_valid;
   logic [2:0]      op_class;
   logic [4:0]      op_alu;
   logic            op_imm_b, op_write, op_iret, op_ien;
   logic [2:0]      op_cond;
   logic [3:0]      op_vector;
   logic            Z, C, S;
   logic [BITS-1:0] regA, regB, imm_reg;
   logic [4:0]      aluOp;
   logic [BITS-1:0] aluA, aluB;
   logic            load_pc;
   logic [AB-1:0]   new_pc;
   logic            int_set, int_clear;
   logic            mem_valid, mem_ready, mem_write;
   logic [AB-1:0]   mem_addr;
   logic [BITS-1:0] mem_wdata, mem_rdata;
   logic            io_valid, io_ready, io_write;
   logic [AB-1:0]   io_addr;
   logic [BITS-1:0] io_wdata, io_rdata;
   logic [BITS-1:0] rdata;
   logic            rdata_valid, stall, bus_error;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   slurm_cpu_execute_hs #(
      .BITS(BITS), .ADDRESS_BITS(AB), .TIMEOUT_CYCLES(8)
   ) dut (
      .CLK(CLK), .RSTb(RSTb), .ins_valid(ins_valid), .op_class(op_class), .op_alu(op_alu),
      .op_imm_b(op_imm_b), .op_write(op_write), .op_cond(op_cond), .op_iret(op_iret),
      .op_ien(op_ien), .op_vector(op_vector), .Z(Z), .C(C), .S(S), .regA(regA), .regB(regB),
      .imm_reg(imm_reg), .aluOp(aluOp), .aluA(aluA), .aluB(aluB), .load_pc(load_pc),
      .new_pc(new_pc), .int_set(int_set), .int_clear(int_clear), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_valid(io_valid), .io_ready(io_ready),
      .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .rdata(rdata), .rdata_valid(rdata_valid), .stall(stall), .bus_error(bus_error)
   );

   task automatic clear_inputs();
      ins_valid = 0; op_class = 0; op_alu = 0; op_imm_b = 0; op_write = 0; op_cond = 0;
      op_iret = 0; op_ien = 0; op_vector = 0; Z = 0; C = 0; S = 0;
      regA = 0; regB = 0; imm_reg = 0;
      mem_ready = 0; mem_rdata = 0; io_ready = 0; io_rdata = 0;
   endtask

   // Advance one clock and return at the next falling edge.
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      clear_inputs();
      RSTb = 0;
      ins_valid = 1; op_class = 3'd5; regB = 16'h1111; regA = 16'h2222;
      repeat (3) step();
      checks++;
      if ({aluOp, aluA, aluB, load_pc, new_pc, int_set, int_clear} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got aluOp=%h aluA=%h aluB=%h load_pc=%b new_pc=%h, want all 0",
                  aluOp, aluA, aluB, load_pc, new_pc);
      end
      checks++;
      if ({mem_valid, mem_write, mem_addr, mem_wdata, io_valid, io_write, io_addr, io_wdata}
          !== '0) begin
         errors++;
         $display("FAIL reset_bus: got mem_valid=%b mem_addr=%h io_valid=%b io_addr=%h, want 0",
                  mem_valid, mem_addr, io_valid, io_addr);
      end
      checks++;
      if ({rdata, rdata_valid, stall, bus_error} !== '0) begin
         errors++;
         $display("FAIL reset_misc: got rdata=%h rdata_valid=%b stall=%b bus_error=%b, want 0",
                  rdata, rdata_valid, stall, bus_error);
      end
      clear_inputs();
      RSTb = 1;
      step();
   endtask

   task automatic test_alu();
      ins_valid = 1; op_class = 3'd1; op_alu = 5'd3; op_imm_b = 1;
      regA = 16'h1234; regB = 16'h5555; imm_reg = 16'h0010;
      step();
      op_imm_b = 0; op_alu = 5'd12; regA = 16'hA0A0; regB = 16'h0F0F;
      checks++;
      if (aluOp !== 5'd3 || aluA !== 16'h1234 || aluB !== 16'h0010 || stall !== 1'b0) begin
         errors++;
         $display("FAIL alu_imm: got op=%h A=%h B=%h stall=%b, want op=03 A=1234 B=0010 stall=0",
                  aluOp, aluA, aluB, stall);
      end
      step();
      clear_inputs();
      checks++;
      if (aluOp !== 5'd12 || aluA !== 16'hA0A0 || aluB !== 16'h0F0F) begin
         errors++;
         $display("FAIL alu_reg: got op=%h A=%h B=%h, want op=0c A=a0a0 B=0f0f", aluOp, aluA, aluB);
      end
      step();
      checks++;
      if (aluOp !== 5'd0) begin
         errors++;
         $display("FAIL alu_idle_noop: got aluOp=%h, want 00", aluOp);
      end
   endtask

   task automatic test_branch();
      ins_valid = 1; op_class = 3'd2; op_cond = 3'd1; Z = 1;
      regA = 16'hFFF0; imm_reg = 16'h0020;
      step();
      Z = 0; regA = 16'h0100;
      checks++;
      if (load_pc !== 1'b1 || new_pc !== 16'h0010 || aluOp !== 5'd0) begin
         errors++;
         $display("FAIL branch_taken: got load_pc=%b new_pc=%h aluOp=%h, want 1 0010 00",
                  load_pc, new_pc, aluOp);
      end
      step();
      checks++;
      if (load_pc !== 1'b0 || new_pc !== 16'h0010) begin
         errors++;
         $display("FAIL branch_not_taken: got load_pc=%b new_pc=%h, want 0 0010", load_pc, new_pc);
      end
      op_class = 3'd3; op_iret = 1; regA = 16'h4321;
      step();
      checks++;
      if (load_pc !== 1'b1 || new_pc !== 16'h4321 || int_set !== 1'b1) begin
         errors++;
         $display("FAIL iret: got load_pc=%b new_pc=%h int_set=%b, want 1 4321 1",
                  load_pc, new_pc, int_set);
      end
      op_class = 3'd4; op_iret = 0; op_vector = 4'd5;
      step();
      checks++;
      if (load_pc !== 1'b1 || new_pc !== 16'h000A || int_set !== 1'b0) begin
         errors++;
         $display("FAIL int_vector: got load_pc=%b new_pc=%h int_set=%b, want 1 000a 0",
                  load_pc, new_pc, int_set);
      end
      op_class = 3'd7; op_ien = 0;
      step();
      clear_inputs();
      checks++;
      if (int_clear !== 1'b1 || int_set !== 1'b0 || load_pc !== 1'b0) begin
         errors++;
         $display("FAIL iflag_clear: got int_clear=%b int_set=%b load_pc=%b, want 1 0 0",
                  int_clear, int_set, load_pc);
      end
      step();
      checks++;
      if (int_clear !== 1'b0) begin
         errors++;
         $display("FAIL iflag_pulse: got int_clear=%b, want 0", int_clear);
      end
   endtask

   task automatic test_store_wait();
      int bad_valid = 0;
      int bad_stall = 0;
      ins_valid = 1; op_class = 3'd5; op_write = 1;
      regB = 16'h0100; imm_reg = 16'h0004; regA = 16'hBEEF;
      step();
      // Instruction fields presented while stalled must be ignored.
      op_class = 3'd1; op_alu = 5'd7; regB = 16'h0000; regA = 16'h0000;
      checks++;
      if (mem_addr !== 16'h0104 || mem_wdata !== 16'hBEEF || mem_write !== 1'b1) begin
         errors++;
         $display("FAIL store_bus: got addr=%h wdata=%h write=%b, want 0104 beef 1",
                  mem_addr, mem_wdata, mem_write);
      end
      for (int i = 0; i < 4; i++) begin
         if (mem_valid !== 1'b1 || mem_addr !== 16'h0104) bad_valid++;
         if (stall !== 1'b1 || aluOp !== 5'd0) bad_stall++;
         if (i == 3) begin
            mem_ready = 1;
            ins_valid = 0;
         end
         step();
      end
      mem_ready = 0;
      checks++;
      if (bad_valid != 0) begin
         errors++;
         $display("FAIL store_valid_hold: got %0d bad cycles, want 0", bad_valid);
      end
      checks++;
      if (bad_stall != 0) begin
         errors++;
         $display("FAIL store_stall_hold: got %0d bad cycles, want 0", bad_stall);
      end
      checks++;
      if (mem_valid !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL store_done: got valid=%b stall=%b rdata_valid=%b, want 0 0 0",
                  mem_valid, stall, rdata_valid);
      end
      clear_inputs();
      // Unpaired ready in idle must not start anything.
      mem_ready = 1; io_ready = 1;
      step();
      clear_inputs();
      checks++;
      if (mem_valid !== 1'b0 || io_valid !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL unpaired_ready: got mem_valid=%b io_valid=%b stall=%b rv=%b, want 0",
                  mem_valid, io_valid, stall, rdata_valid);
      end
   endtask

   task automatic test_zero_wait_peek();
      io_ready = 1; io_rdata = 16'h5A5A;
      ins_valid = 1; op_class = 3'd6; op_write = 0;
      regA = 16'h7777; regB = 16'h0020; imm_reg = 16'h0003;
      step();
      ins_valid = 0;
      checks++;
      if (io_valid !== 1'b1 || stall !== 1'b1 || io_addr !== 16'h0023 || io_write !== 1'b0 ||
          io_wdata !== 16'h0000) begin
         errors++;
         $display("FAIL peek_req: got valid=%b stall=%b addr=%h write=%b wdata=%h, want 1 1 0023 0 0",
                  io_valid, stall, io_addr, io_write, io_wdata);
      end
      step();
      io_ready = 0; io_rdata = 16'h0000;
      checks++;
      if (io_valid !== 1'b0 || stall !== 1'b0 || rdata !== 16'h5A5A || rdata_valid !== 1'b1) begin
         errors++;
         $display("FAIL peek_resp: got valid=%b stall=%b rdata=%h rv=%b, want 0 0 5a5a 1",
                  io_valid, stall, rdata, rdata_valid);
      end
      step();
      checks++;
      if (rdata !== 16'h5A5A || rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL peek_hold: got rdata=%h rv=%b, want 5a5a 0", rdata, rdata_valid);
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      ins_valid = 1; op_class = 3'd5; op_write = 0; regB = 16'h0200; imm_reg = 16'h0010;
      step();
      ins_valid = 0;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 16'h0210 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL load_req: got valid=%b addr=%h write=%b, want 1 0210 0",
                  mem_valid, mem_addr, mem_write);
      end
      step();
      mem_ready = 1; mem_rdata = 16'h1357;
      step();
      clear_inputs();
      checks++;
      if (rdata_valid !== 1'b1 || rdata !== 16'h1357 || stall !== 1'b0) begin
         errors++;
         $display("FAIL load_resp: got rv=%b rdata=%h stall=%b, want 1 1357 0",
                  rdata_valid, rdata, stall);
      end
      // New instruction accepted in the rdata_valid cycle.
      ins_valid = 1; op_class = 3'd1; op_alu = 5'd9; op_imm_b = 0;
      regA = 16'h0001; regB = 16'h0042;
      step();
      clear_inputs();
      checks++;
      if (aluOp !== 5'd9 || aluB !== 16'h0042 || rdata_valid !== 1'b0 || rdata !== 16'h1357) begin
         errors++;
         $display("FAIL back_to_back: got op=%h B=%h rv=%b rdata=%h, want 09 0042 0 1357",
                  aluOp, aluB, rdata_valid, rdata);
      end
   endtask

   task automatic test_reset_mid_access();
      int rv_seen = 0;
      ins_valid = 1; op_class = 3'd5; op_write = 0; regB = 16'h0300;
      step();
      ins_valid = 0;
      step();
      RSTb = 0;
      step();
      checks++;
      if (mem_valid !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid: got valid=%b stall=%b rv=%b rdata=%h, want 0 0 0 0000",
                  mem_valid, stall, rdata_valid, rdata);
      end
      RSTb = 1;
      mem_ready = 1; mem_rdata = 16'hDEAD;
      for (int i = 0; i < 4; i++) begin
         if (rdata_valid !== 1'b0 || mem_valid !== 1'b0) rv_seen++;
         step();
      end
      checks++;
      if (rv_seen != 0) begin
         errors++;
         $display("FAIL reset_abandon: got %0d cycles with rdata_valid/mem_valid, want 0", rv_seen);
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
`ifdef SLURM_EXEC_TIMEOUT_EN
      int valid_cycles = 0;
      int seen = 0;
      ins_valid = 1; op_class = 3'd5; op_write = 0; regB = 16'h0400;
      step();
      clear_inputs();
      for (int i = 0; i < 20 && seen == 0; i++) begin
         if (bus_error === 1'b1) seen = 1;
         else begin
            if (mem_valid === 1'b1) valid_cycles++;
            step();
         end
      end
      checks++;
      if (seen != 1 || valid_cycles != 8) begin
         errors++;
         $display("FAIL timeout: got seen=%0d valid_cycles=%0d, want 1 8", seen, valid_cycles);
      end
      checks++;
      if (mem_valid !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: got valid=%b stall=%b rv=%b, want 0 0 0",
                  mem_valid, stall, rdata_valid);
      end
      step();
      checks++;
      if (bus_error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: got bus_error=%b, want 0", bus_error);
      end
`else
      int bad = 0;
      ins_valid = 1; op_class = 3'd5; op_write = 1; regA = 16'h0BAD; regB = 16'h0500;
      step();
      clear_inputs();
      for (int i = 0; i < 100; i++) begin
         if (stall !== 1'b1 || mem_valid !== 1'b1 || bus_error !== 1'b0) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL no_timeout_wait: got %0d bad cycles of 100, want 0", bad);
      end
      mem_ready = 1;
      step();
      mem_ready = 0;
      checks++;
      if (stall !== 1'b0 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_release: got stall=%b valid=%b, want 0 0", stall, mem_valid);
      end
`endif
   endtask

   initial begin
      clear_inputs();
      RSTb = 0;
      @(negedge CLK);
      test_reset();
      test_alu();
      test_branch();
      test_store_wait();
      test_zero_wait_peek();
      test_back_to_back();
      test_reset_mid_access();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/slurm_cpu_execute_hs.md
# slurm_cpu_execute_hs

Parametrised execute stage for the SLURM CPU core, successor to the single-cycle execute stage. It adds a valid/ready handshake on memory and port accesses, pipeline stall generation while an access is outstanding, registered branch and interrupt-flag outputs, and widths set by parameters. It sits between the register-read stage and the ALU, memory arbiter and port bus, and consumes pre-decoded instruction fields.

## Interface
- BITS, 16, data width
- ADDRESS_BITS, 16, memory/port address width
- TIMEOUT_CYCLES, 255, bus timeout limit; used only with SLURM_EXEC_TIMEOUT_EN
- CLK  in  1  clock
- RSTb  in  1  reset; synchronous, active-low; clock CLK
- ins_valid  in  1  decoded instruction present this cycle
- op_class  in  3  0 NOP, 1 ALU, 2 BRANCH, 3 RET, 4 INT, 5 LDST, 6 IO, 7 IFLAG
- op_alu  in  5  ALU opcode
- op_imm_b  in  1  ALU operand B comes from imm_reg
- op_write  in  1  store/poke when 1, load/peek when 0
- op_cond  in  3  branch condition code
- op_iret  in  1  RET is an iret
- op_ien  in  1  IFLAG: 1 sets, 0 clears
- op_vector  in  4  INT vector
- Z, C, S  in  1 each  flags
- regA, regB, imm_reg  in  BITS  operands
- aluOp  out  5; aluA, aluB  out  BITS each
- load_pc  out  1; new_pc  out  ADDRESS_BITS
- int_set, int_clear  out  1 each
- mem_valid  out  1; mem_ready  in  1; mem_write  out  1
- mem_addr  out  ADDRESS_BITS; mem_wdata  out  BITS; mem_rdata  in  BITS
- io_valid  out  1; io_ready  in  1; io_write  out  1
- io_addr  out  ADDRESS_BITS; io_wdata  out  BITS; io_rdata  in  BITS
- rdata  out  BITS; rdata_valid  out  1 (load/peek result)
- stall  out  1 (hold upstream stages)
- bus_error  out  1 (timeout pulse; SLURM_EXEC_TIMEOUT_EN only)

## Operation
- FSM states: IDLE, MEM_WAIT, IO_WAIT. Reset enters IDLE.
- Instructions are accepted only in IDLE with ins_valid=1. In the other states the inputs are ignored, and upstream holds them because stall=1.
- ALU: aluA=regA; aluB = op_imm_b ? imm_reg : regB; aluOp=op_alu. Every other accepted class, and any cycle with no accepted instruction, loads aluOp=0 (mov/noop).
- BRANCH conditions: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 !S, 7 never. When taken: new_pc = regA+imm_reg, truncated to ADDRESS_BITS.
- RET: new_pc=regA. When op_iret=1, also int_set.
- INT: new_pc = {zeros, op_vector, 1'b0}.
- IFLAG: op_ien=1 gives int_set, otherwise int_clear.
- LDST: mem_addr = regB+imm_reg (wraps modulo 2^ADDRESS_BITS); mem_wdata = regA when writing, otherwise 0. Go to MEM_WAIT.
- IO: same scheme on the io_* bus. Go to IO_WAIT.
- MEM_WAIT/IO_WAIT: valid, address, write and wdata stay stable until the cycle in which ready=1. That cycle is the handshake; the next cycle returns to IDLE.
- Load/peek: rdata captures mem_rdata or io_rdata at the handshake. rdata holds until the next load.

## Timing
- All outputs are registered and appear one cycle after acceptance.
- load_pc, int_set, int_clear and rdata_valid are single-cycle pulses.
- Reset values: every output 0, including rdata and the address/data buses.
- Bus access: mem_valid/io_valid rise 1 cycle after acceptance.
- stall is combinational: 1 in MEM_WAIT/IO_WAIT, 0 in IDLE.
  - If ready is already 1 when valid first rises, the access takes 1 cycle and stall is high that 1 cycle.
  - N wait cycles give N+1 stall cycles.
- rdata_valid pulses the cycle after the handshake, in IDLE. A new instruction may be accepted in that same cycle.
- A ready that is not paired with valid is ignored.
- RSTb=0 mid-access: the FSM returns to IDLE immediately, valid drops, and the access is abandoned with no rdata_valid.
- Only one instruction is executed at a time, so a simultaneous branch and memory access cannot occur.

## Configuration
- SLURM_EXEC_TIMEOUT_EN defined:
  - An 8+-bit wait counter clears on entry to MEM_WAIT/IO_WAIT and increments each wait cycle.
  - On reaching TIMEOUT_CYCLES without ready: drop valid, return to IDLE, pulse bus_error for 1 cycle, no rdata_valid. Loads leave rdata unchanged.
- Undefined: there is no counter, the FSM waits indefinitely, and bus_error is tied to 0.

## Test plan
- ALU imm: op_class=1, op_alu=3, op_imm_b=1, regA=0x1234, imm_reg=0x0010 -> next cycle aluOp=3, aluA=0x1234, aluB=0x0010.
- Branch: op_cond=1, Z=1, regA=0xFFF0, imm_reg=0x0020 -> load_pc pulse, new_pc=0x0010 (wrap). With Z=0 -> load_pc stays 0.
- Store with 3 wait states: regB=0x0100, imm=4, regA=0xBEEF -> mem_addr=0x0104, mem_wdata=0xBEEF, mem_write=1. mem_valid is held for 4 cycles and stall for 4 cycles.
- Zero-wait peek: io_ready=1, io_rdata=0x5A5A -> io_valid for 1 cycle; rdata=0x5A5A and rdata_valid the following cycle.
- Reset mid-load in MEM_WAIT -> the next cycle mem_valid=0, stall=0, rdata_valid never asserts.
- With SLURM_EXEC_TIMEOUT_EN and TIMEOUT_CYCLES=8, ready never asserted -> bus_error pulses after 8 wait cycles and the FSM returns to IDLE. Without the macro, stall stays 1 for 100 cycles.
